// File: rtl/ssp_apb_regfifo.sv
// ssp_apb_regfifo: PL022-style SSP APB register block with integrated TX/RX FIFOs,
// sticky/level interrupt status, write-one-to-clear ICR, receive timeout and DMA requests.
// Optional macro SSP_PERIPH_ID_EN maps read-only peripheral ID registers at 0xFE0-0xFFC;
// without it those offsets are unmapped.
module ssp_apb_regfifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RT_CYCLES  = 32,
  parameter int ADDR_W     = 12
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:2] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              core_busy,
  output logic [15:0]       cr0_o,
  output logic [3:0]        cr1_o,
  output logic [7:0]        cpsr_o,
  output logic              txintr,
  output logic              rxintr,
  output logic              rtintr,
  output logic              rorintr,
  output logic              intr,
  output logic              txdmareq,
  output logic              rxdmareq
);
  localparam int AW = ADDR_W - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(RT_CYCLES + 1);
  localparam logic [CW-1:0] HALF = CW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [15:0] cr0;
  logic [3:0]  cr1;
  logic [7:0]  cpsr;
  logic [3:0]  imsc;
  logic [1:0]  dmacr;
  logic        ror, rt;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0]     tx_count, rx_count;
  logic [TW-1:0]     rt_cnt;

  logic        tx_empty, tx_full, rx_empty, rx_full, sse;
  logic [4:0]  sr;
  logic [3:0]  ris, mis;
  logic        bad, access, wr_ok, rd_ok, dr_hit, icr_wr;
  logic        tx_push, tx_pop, rx_push, rx_pop, ror_set, rt_set, rt_reload;
  logic [15:0] rdata, wdata16;

  // Timeout counter step that sticks once the threshold is reached.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TW'(RT_CYCLES)) ? v : v + TW'(1);
  endfunction

`ifdef SSP_PERIPH_ID_EN
  function automatic logic [7:0] id_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h22;
      3'd1:    return 8'h10;
      3'd2:    return 8'h34;
      3'd3:    return 8'h00;
      3'd4:    return 8'h0D;
      3'd5:    return 8'hF0;
      3'd6:    return 8'h05;
      default: return 8'hB1;
    endcase
  endfunction
`endif

  assign wdata16  = 16'(PWDATA);
  assign sse      = cr1[1];
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL);
  assign sr       = {core_busy | (sse & ~tx_empty), rx_full, ~rx_empty, ~tx_full, tx_empty};
  assign ris      = {tx_count <= HALF, rx_count >= HALF, rt, ror};
  assign mis      = ris & imsc;

  // Address decode, read mux and error classification for the current access.
  always_comb begin
    bad   = 1'b0;
    rdata = '0;
    case (PADDR)
      AW'(0): rdata = cr0;
      AW'(1): rdata = {12'd0, cr1};
      AW'(2): rdata = rx_empty ? 16'd0 : 16'(rx_mem[rx_rptr]);
      AW'(3): begin rdata = {11'd0, sr};  bad = PWRITE; end
      AW'(4): rdata = {8'd0, cpsr};
      AW'(5): rdata = {12'd0, imsc};
      AW'(6): begin rdata = {12'd0, ris}; bad = PWRITE; end
      AW'(7): begin rdata = {12'd0, mis}; bad = PWRITE; end
      AW'(8): bad = ~PWRITE;
      AW'(9): rdata = {14'd0, dmacr};
      default: begin
`ifdef SSP_PERIPH_ID_EN
        if ((PADDR >> 3) == AW'(7'h7F)) begin
          rdata = {8'd0, id_byte(PADDR[4:2])};
          bad   = PWRITE;
        end else begin
          bad = 1'b1;
        end
`else
        bad = 1'b1;
`endif
      end
    endcase
  end

  assign access  = PSEL & PENABLE;
  assign wr_ok   = access & PWRITE & ~bad;
  assign rd_ok   = access & ~PWRITE & ~bad;
  assign dr_hit  = (PADDR == AW'(2));
  assign icr_wr  = wr_ok & (PADDR == AW'(8));
  assign PREADY  = 1'b1;
  assign PSLVERR = access & bad;
  assign PRDATA  = (PSEL & ~PWRITE & ~bad) ? DATA_W'(rdata) : '0;

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_push   = wr_ok & dr_hit & (~tx_full | tx_pop);
  assign rx_pop    = rd_ok & dr_hit & ~rx_empty;
  assign rx_push   = rx_valid & (~rx_full | rx_pop);
  assign ror_set   = rx_valid & rx_full & ~rx_pop;
  assign rt_reload = rx_empty | rx_push | rx_pop;
  assign rt_set    = ~rt_reload & (rt_cnt == TW'(RT_CYCLES - 1));

  assign tx_valid = sse & ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rptr];

  // Control registers written from APB.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cr0   <= '0;
      cr1   <= '0;
      cpsr  <= '0;
      imsc  <= '0;
      dmacr <= '0;
    end else if (wr_ok) begin
      case (PADDR)
        AW'(0):  cr0   <= wdata16;
        AW'(1):  cr1   <= wdata16[3:0];
        AW'(4):  cpsr  <= {wdata16[7:1], 1'b0};
        AW'(5):  imsc  <= wdata16[3:0];
        AW'(9):  dmacr <= wdata16[1:0];
        default: ;
      endcase
    end
  end

  // Sticky overrun/timeout status; a set in the clearing cycle wins.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ror <= 1'b0;
      rt  <= 1'b0;
    end else begin
      ror <= ror_set | (ror & ~(icr_wr & wdata16[0]));
      rt  <= rt_set  | (rt  & ~(icr_wr & wdata16[1]));
    end
  end

  // Receive inactivity counter.
  always_ff @(posedge PCLK) begin
    if (PRESET)         rt_cnt <= '0;
    else if (rt_reload) rt_cnt <= '0;
    else                rt_cnt <= sat_inc(rt_cnt);
  end

  // FIFO storage; contents are qualified by the counts, so no reset.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wptr] <= PWDATA;
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (tx_push & ~tx_pop)      tx_count <= tx_count + CW'(1);
      else if (~tx_push & tx_pop) tx_count <= tx_count - CW'(1);
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      if (rx_push & ~rx_pop)      rx_count <= rx_count + CW'(1);
      else if (~rx_push & rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  assign cr0_o    = cr0;
  assign cr1_o    = cr1;
  assign cpsr_o   = cpsr;
  assign txintr   = mis[3];
  assign rxintr   = mis[2];
  assign rtintr   = mis[1];
  assign rorintr  = mis[0];
  assign intr     = |mis;
  assign txdmareq = dmacr[1] & ris[3];
  assign rxdmareq = dmacr[0] & (ris[2] | ris[1]);

endmodule

// File: tb/tb_ssp_apb_regfifo.sv
// tb_ssp_apb_regfifo: directed bench for ssp_apb_regfifo with hand-computed expectations.
`timescale 1ns/1ps
module tb_ssp_apb_regfifo;
  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [15:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, core_busy;
  logic [15:0] cr0_o;
  logic [3:0]  cr1_o;
  logic [7:0]  cpsr_o;
  logic        txintr, rxintr, rtintr, rorintr, intr, txdmareq, rxdmareq;

  int n_checks = 0;
  int n_errors = 0;

  ssp_apb_regfifo #(.DATA_W(16), .FIFO_DEPTH(8), .RT_CYCLES(32), .ADDR_W(12)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .core_busy(core_busy),
    .cr0_o(cr0_o), .cr1_o(cr1_o), .cpsr_o(cpsr_o),
    .txintr(txintr), .rxintr(rxintr), .rtintr(rtintr), .rorintr(rorintr), .intr(intr),
    .txdmareq(txdmareq), .rxdmareq(rxdmareq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr[11:2]; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] addr, input logic [15:0] wdata);
    logic [15:0] d;
    logic e;
    apb_xfer(1'b1, addr, wdata, d, e);
  endtask

  task automatic rx_push(input logic [15:0] d);
    @(negedge PCLK);
    rx_valid = 1'b1; rx_data = d;
    @(posedge PCLK);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        err;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; core_busy = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(PREADY), 1);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_intr", 32'(intr), 0);
    check("rst_txdmareq", 32'(txdmareq), 0);
    check("rst_cr0", 32'(cr0_o), 0);
    check("rst_prdata", 32'(PRDATA), 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("rst_sr", 32'(rd), 32'h03);
    check("rst_sr_err", 32'(err), 0);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("rst_ris", 32'(rd), 32'h8);
    apb_xfer(1'b0, 12'h01C, 16'h0, rd, err);
    check("rst_mis", 32'(rd), 32'h0);
    check("rst_intr2", 32'(intr), 0);
    core_busy = 1'b1;
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("sr_busy", 32'(rd), 32'h13);
    core_busy = 1'b0;

    apb_wr(12'h000, 16'hABCD);
    check("cr0_o", 32'(cr0_o), 32'hABCD);
    apb_wr(12'h010, 16'h00FF);
    check("cpsr_o", 32'(cpsr_o), 32'hFE);
    apb_xfer(1'b0, 12'h010, 16'h0, rd, err);
    check("cpsr_rd", 32'(rd), 32'hFE);

    // TX: nine writes with SSE=0, ninth dropped
    for (int i = 1; i <= 9; i++) apb_wr(12'h008, 16'(i));
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("tx_full_sr", 32'(rd), 32'h00);
    check("tx_hold", 32'(tx_valid), 0);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("tx_full_ris", 32'(rd), 32'h0);
    tx_ready = 1'b1;
    apb_wr(12'h004, 16'h0002);
    for (int i = 1; i <= 8; i++) begin
      check("tx_valid_seq", 32'(tx_valid), 1);
      check("tx_data_seq", 32'(tx_data), 32'(i));
      @(posedge PCLK);
      #1;
    end
    check("tx_drained", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // RX overflow and ICR clear
    for (int i = 1; i <= 9; i++) rx_push(16'(32'h100 + i));
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("rx_full_sr", 32'(rd), 32'h0F);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("ror_ris", 32'(rd), 32'hD);
    check("ror_masked", 32'(rorintr), 0);
    apb_wr(12'h014, 16'h0001);
    check("rorintr", 32'(rorintr), 1);
    check("ror_intr", 32'(intr), 1);
    apb_wr(12'h020, 16'h0001);
    check("ror_clr", 32'(rorintr), 0);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("ror_clr_ris", 32'(rd), 32'hC);

    // DR read of full FIFO with simultaneous rx_valid: accepted, no ROR
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 10'h2;
    @(negedge PCLK);
    PENABLE = 1'b1; rx_valid = 1'b1; rx_data = 16'h01AA;
    #1;
    rd = PRDATA;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    check("simul_rd", 32'(rd), 32'h101);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("simul_no_ror", 32'(rd), 32'hC);
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("simul_sr", 32'(rd), 32'h0F);
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 12'h008, 16'h0, rd, err);
      check("rx_drain", 32'(rd), (i < 7) ? 32'h102 + 32'(i) : 32'h1AA);
    end
    apb_xfer(1'b0, 12'h008, 16'h0, rd, err);
    check("rx_empty_rd", 32'(rd), 32'h0);
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("rx_empty_sr", 32'(rd), 32'h03);

    // Receive timeout: asserts exactly 32 cycles after the push edge
    apb_wr(12'h014, 16'h0002);
    rx_push(16'h0055);
    repeat (31) @(posedge PCLK);
    #1;
    check("rt_early", 32'(rtintr), 0);
    @(posedge PCLK);
    #1;
    check("rt_on_time", 32'(rtintr), 1);
    check("rt_intr", 32'(intr), 1);
    apb_xfer(1'b0, 12'h008, 16'h0, rd, err);
    check("rt_word", 32'(rd), 32'h55);
    apb_wr(12'h020, 16'h0002);
    check("rt_clr", 32'(rtintr), 0);
    repeat (40) @(posedge PCLK);
    #1;
    check("rt_idle_empty", 32'(rtintr), 0);
    apb_xfer(1'b0, 12'h018, 16'h0, rd, err);
    check("rt_ris", 32'(rd), 32'h8);

    // DMA requests
    apb_xfer(1'b1, 12'h024, 16'h0003, rd, err);
    check("dmacr_err", 32'(err), 0);
    check("rxdma_idle", 32'(rxdmareq), 0);
    check("txdma_empty", 32'(txdmareq), 1);
    for (int i = 0; i < 3; i++) rx_push(16'(32'h200 + i));
    check("rxdma_3", 32'(rxdmareq), 0);
    rx_push(16'h0203);
    check("rxdma_4", 32'(rxdmareq), 1);
    for (int i = 0; i < 4; i++) apb_wr(12'h008, 16'(32'h11 + i));
    check("txdma_4", 32'(txdmareq), 1);
    check("tx_head", 32'(tx_data), 32'h11);
    apb_wr(12'h008, 16'h0015);
    check("txdma_5", 32'(txdmareq), 0);
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("dma_sr", 32'(rd), 32'h16);

    // Error responses
    apb_xfer(1'b1, 12'h018, 16'h000F, rd, err);
    check("wr_ris_err", 32'(err), 1);
    apb_xfer(1'b1, 12'h00C, 16'h001F, rd, err);
    check("wr_sr_err", 32'(err), 1);
    apb_xfer(1'b0, 12'h020, 16'h0, rd, err);
    check("rd_icr_err", 32'(err), 1);
    check("rd_icr_data", 32'(rd), 0);
    apb_xfer(1'b0, 12'h030, 16'h0, rd, err);
    check("rd_unmap_err", 32'(err), 1);
    check("rd_unmap_data", 32'(rd), 0);
    apb_xfer(1'b0, 12'h00C, 16'h0, rd, err);
    check("err_sr_same", 32'(rd), 32'h16);
    apb_xfer(1'b0, 12'h014, 16'h0, rd, err);
    check("err_imsc_same", 32'(rd), 32'h2);
    apb_xfer(1'b0, 12'hFE0, 16'h0, rd, err);
`ifdef SSP_PERIPH_ID_EN
    check("id0_data", 32'(rd), 32'h22);
    check("id0_err", 32'(err), 0);
`else
    check("id0_data", 32'(rd), 32'h0);
    check("id0_err", 32'(err), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
